cmd_issuer: RTL

Host-side command initiator for the matrix accelerator's command interface. On a single `start_i` pulse it captures a job descriptor. It then drives the fixed command sequence cmd.size → cmd.addrW → cmd.addrX → cmd.addrR → cmd.initiate over the cmd valid/ready channel, one command per handshake. It sits between the host/testbench job source and the ASIC's command receiver, and reports completion or error back to the job source.

---
 rtl/cmd_pkg.sv | 72 +++++++
 rtl/cmd_issuer_if.sv | 29 ++
 rtl/cmd_timeout_ctr.sv | 37 +++
 rtl/cmd_issuer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Shared command-interface definitions for the matrix accelerator: funct codes, mode codes,
// issuer states and the job descriptor used on both the issuer and receiver sides.
package cmd_pkg;

  localparam logic [6:0] FunctInitiate = 7'h01;
  localparam logic [6:0] FunctSize     = 7'h02;
  localparam logic [6:0] FunctAddrW    = 7'h04;
  localparam logic [6:0] FunctAddrX    = 7'h06;
  localparam logic [6:0] FunctAddrR    = 7'h08;

  localparam logic [6:0] ModeYPrime8  = 7'h00;
  localparam logic [6:0] ModeYPrime16 = 7'h01;
  localparam logic [6:0] ModeZ8       = 7'h02;
  localparam logic [6:0] ModeZ16      = 7'h03;
  localparam logic [6:0] ModePhi8     = 7'h04;
  localparam logic [6:0] ModePhi16    = 7'h05;

  typedef enum logic [2:0] {
    StIdle,
    StSize,
    StAddrW,
    StAddrX,
    StAddrR,
    StInit
  } cmd_issuer_state_t;

  typedef struct packed {
    logic [6:0]  mode;
    logic [15:0] m_size;
    logic [15:0] n_size;
    logic [63:0] addr_w;
    logic [63:0] addr_x;
    logic [63:0] addr_r;
  } cmd_job_t;

  function automatic logic job_legal(cmd_job_t job);
    return (job.mode <= ModePhi16) && (job.m_size != '0) && (job.n_size != '0);
  endfunction

  function automatic cmd_issuer_state_t cmd_next_state(cmd_issuer_state_t st);
    case (st)
      StSize:  return StAddrW;
      StAddrW: return StAddrX;
      StAddrX: return StAddrR;
      StAddrR: return StInit;
      default: return StIdle;
    endcase
  endfunction

  function automatic logic [6:0] cmd_funct(cmd_issuer_state_t st);
    case (st)
      StSize:  return FunctSize;
      StAddrW: return FunctAddrW;
      StAddrX: return FunctAddrX;
      StAddrR: return FunctAddrR;
      StInit:  return FunctInitiate;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [63:0] cmd_payload(cmd_issuer_state_t st, cmd_job_t job);
    case (st)
      StSize:  return {32'h0, job.n_size, job.m_size};
      StAddrW: return job.addr_w;
      StAddrX: return job.addr_x;
      StAddrR: return job.addr_r;
      StInit:  return {57'h0, job.mode};
      default: return 64'h0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_issuer_if.sv
// Command valid/ready channel between the host-side issuer (master) and the ASIC receiver (slave).
interface cmd_issuer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_inst_funct;
  logic [6:0]  cmd_inst_opcode;
  logic [4:0]  cmd_inst_rs1;
  logic [63:0] cmd_rs1;

  modport master (
    output cmd_valid,
    output cmd_inst_funct,
    output cmd_inst_opcode,
    output cmd_inst_rs1,
    output cmd_rs1,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_inst_funct,
    input  cmd_inst_opcode,
    input  cmd_inst_rs1,
    input  cmd_rs1,
    output cmd_ready
  );

endinterface

// File: rtl/cmd_timeout_ctr.sv
// Stall counter for cmd_issuer: clears on clr, counts on inc, pulses tc on the Limit-th count.
// Only instantiated when CMD_ISSUER_TIMEOUT_EN is defined.
module cmd_timeout_ctr #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(Limit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc = inc && (cnt_q == TcVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tc) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_issuer.sv
// Host-side command initiator: captures a job on start_i and issues size/addrW/addrX/addrR/initiate.
// Optional stall abort is compiled in with CMD_ISSUER_TIMEOUT_EN.
module cmd_issuer
  import cmd_pkg::*;
#(
  parameter logic [6:0] OPCODE      = 7'b000_1011,
  parameter logic [4:0] RS1_IDX     = 5'd1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [6:0]        mode_i,
  input  logic [15:0]       m_size_i,
  input  logic [15:0]       n_size_i,
  input  logic [63:0]       addr_w_i,
  input  logic [63:0]       addr_x_i,
  input  logic [63:0]       addr_r_i,
  cmd_issuer_if.master      cmd,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  if (TIMEOUT_CYC == 0) begin : g_timeout_check
    $error("TIMEOUT_CYC must be non-zero");
  end

  cmd_issuer_state_t state_q, state_d;
  cmd_job_t          job_q, job_d, job_in;
  logic              valid_q, valid_d;
  logic [6:0]        funct_q, funct_d;
  logic [63:0]       rs1_q, rs1_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              idle, xfer, timeout_hit;

  assign job_in = '{mode: mode_i, m_size: m_size_i, n_size: n_size_i,
                    addr_w: addr_w_i, addr_x: addr_x_i, addr_r: addr_r_i};

  assign idle = (state_q == StIdle);
  assign xfer = valid_q && cmd.cmd_ready;

`ifdef CMD_ISSUER_TIMEOUT_EN
  logic stall, ctr_clr;
  assign stall   = valid_q && !cmd.cmd_ready;
  assign ctr_clr = xfer || (idle && start_i);

  cmd_timeout_ctr #(
    .Limit(TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (ctr_clr),
    .inc  (stall),
    .tc   (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Outputs are registered, so the next command's funct/payload is computed one state ahead.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    valid_d = valid_q;
    funct_d = funct_q;
    rs1_d   = rs1_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (idle) begin
      if (start_i) begin
        job_d = job_in;
        if (!job_legal(job_in)) begin
          err_d = 1'b1;
        end else begin
          state_d = StSize;
          valid_d = 1'b1;
          funct_d = cmd_funct(StSize);
          rs1_d   = cmd_payload(StSize, job_in);
        end
      end
    end else if (xfer) begin
      state_d = cmd_next_state(state_q);
      if (state_d == StIdle) begin
        valid_d = 1'b0;
        funct_d = '0;
        rs1_d   = '0;
        done_d  = 1'b1;
      end else begin
        valid_d = 1'b1;
        funct_d = cmd_funct(state_d);
        rs1_d   = cmd_payload(state_d, job_q);
      end
    end else if (timeout_hit) begin
      state_d = StIdle;
      valid_d = 1'b0;
      funct_d = '0;
      rs1_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      job_q   <= '0;
      valid_q <= 1'b0;
      funct_q <= '0;
      rs1_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
      valid_q <= valid_d;
      funct_q <= funct_d;
      rs1_q   <= rs1_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd.cmd_valid       = valid_q;
  assign cmd.cmd_inst_funct  = funct_q;
  assign cmd.cmd_inst_opcode = OPCODE;
  assign cmd.cmd_inst_rs1    = RS1_IDX;
  assign cmd.cmd_rs1         = rs1_q;
  assign busy_o              = !idle;
  assign done_o              = done_q;
  assign err_o               = err_q;

endmodule
